// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and constants for the elevator motor drive path:
//                sequencer state enum, direction encoding, default timings.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Motor drive sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RELEASE = 3'd1,
        RAMP_UP = 3'd2,
        RUN     = 3'd3,
        RAMP_DN = 3'd4,
        SETTLE  = 3'd5,
        FAULT   = 3'd6
    } state_e;

    // Direction encoding shared with the elevator controller
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Default timing constants
    localparam int DEF_PWM_W         = 8;
    localparam int DEF_DUTY_MAX      = 200;
    localparam int DEF_RAMP_STEP_CYC = 4;
    localparam int DEF_BRAKE_CYC     = 16;
    localparam int DEF_DEAD_CYC      = 8;

endpackage
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_gen
//  Description : Free-running PWM_W-bit counter with duty compare and a
//                registered PWM output gated by the bridge enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;
    logic             pwm_q;
    logic             pwm_d;

    // en and duty are the values the parent registers on this same edge, and
    // the compare uses the post-edge count, so pwm lines up with the visible
    // drive/duty outputs in the same cycle.
    assign cnt_d = cnt_q + PWM_W'(1);
    assign pwm_d = en && (cnt_d < duty);

    // Counter wraps naturally from all-ones to zero; pwm is a plain flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/motor_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motor_drive_sequencer
//  Description : Converts controller run/direction levels into safe motor
//                drive: brake sequencing, soft-start/stop duty ramp, PWM,
//                reversal dead time through IDLE, and a latched safety fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_drive_sequencer
    import elevator_pkg::*;
#(
    parameter int PWM_W         = DEF_PWM_W,
    parameter int DUTY_MAX      = DEF_DUTY_MAX,
    parameter int RAMP_STEP_CYC = DEF_RAMP_STEP_CYC,
    parameter int BRAKE_CYC     = DEF_BRAKE_CYC,
    parameter int DEAD_CYC      = DEF_DEAD_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             motor_cmd,
    input  logic             dir_cmd,
    input  logic             door_closed,
    input  logic             estop,
    input  logic             fault_clr,
    output logic             drv_up,
    output logic             drv_dn,
    output logic             pwm,
    output logic             brake,
    output logic [PWM_W-1:0] duty,
    output logic             busy,
    output logic             fault
);

    localparam int TMR_MAX = (BRAKE_CYC > DEAD_CYC) ? BRAKE_CYC : DEAD_CYC;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int PS_W    = (RAMP_STEP_CYC > 2) ? $clog2(RAMP_STEP_CYC) : 1;

    localparam logic [TMR_W-1:0] BRAKE_LOAD = TMR_W'(BRAKE_CYC - 1);
    localparam logic [TMR_W-1:0] DEAD_LOAD  = TMR_W'(DEAD_CYC - 1);
    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(RAMP_STEP_CYC - 1);
    localparam logic [PWM_W-1:0] DUTY_TOP   = PWM_W'(DUTY_MAX);

    state_e           state_q, state_d;
    logic             dir_lat_q, dir_lat_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             brake_q, brake_d;
    logic             drv_up_q, drv_up_d;
    logic             drv_dn_q, drv_dn_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic             w_moving;
    logic             w_trip;
    logic             w_step;
    logic             w_keep_going;
    logic             w_drive_on;

    // Door opening is only unsafe once the brake has been lifted.
    assign w_moving     = (state_q == RELEASE) || (state_q == RAMP_UP) ||
                          (state_q == RUN)     || (state_q == RAMP_DN);
    assign w_trip       = estop || (!door_closed && w_moving);
    assign w_step       = (presc_q == PS_LAST);
    assign w_keep_going = motor_cmd && (dir_cmd == dir_lat_q);

    // State, timers, ramp and registered outputs; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_lat_q <= DIR_DN;
            timer_q   <= '0;
            presc_q   <= '0;
            duty_q    <= '0;
            brake_q   <= 1'b1;
            drv_up_q  <= 1'b0;
            drv_dn_q  <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_lat_q <= dir_lat_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            duty_q    <= duty_d;
            brake_q   <= brake_d;
            drv_up_q  <= drv_up_d;
            drv_dn_q  <= drv_dn_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state, timer and duty ramp; a trip overrides every other move.
    always_comb begin
        state_d   = state_q;
        dir_lat_d = dir_lat_q;
        timer_d   = timer_q;
        presc_d   = presc_q;
        duty_d    = duty_q;

        if (w_trip) begin
            state_d = FAULT;
            duty_d  = '0;
            timer_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (motor_cmd && door_closed) begin
                        state_d   = RELEASE;
                        dir_lat_d = dir_cmd;
                        timer_d   = BRAKE_LOAD;
                    end
                end
                RELEASE: begin
                    if (!motor_cmd) begin
                        state_d = SETTLE;
                        timer_d = DEAD_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = RAMP_UP;
                        presc_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                RAMP_UP: begin
                    if (!w_keep_going) begin
                        state_d = RAMP_DN;
                        presc_d = '0;
                    end else if (duty_q >= DUTY_TOP) begin
                        // Resumed before the first down-step: already at top.
                        state_d = RUN;
                        duty_d  = DUTY_TOP;
                    end else if (w_step) begin
                        presc_d = '0;
                        duty_d  = duty_q + PWM_W'(1);
                        if (duty_q == DUTY_TOP - PWM_W'(1)) begin
                            state_d = RUN;
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                RUN: begin
                    duty_d = DUTY_TOP;
                    if (!w_keep_going) begin
                        state_d = RAMP_DN;
                        presc_d = '0;
                    end
                end
                RAMP_DN: begin
                    // A reversed request keeps ramping down; reversal goes via IDLE.
                    if (w_keep_going) begin
                        state_d = RAMP_UP;
                        presc_d = '0;
                    end else if (duty_q == '0) begin
                        state_d = SETTLE;
                        timer_d = DEAD_LOAD;
                    end else if (w_step) begin
                        presc_d = '0;
                        duty_d  = duty_q - PWM_W'(1);
                        if (duty_q == PWM_W'(1)) begin
                            state_d = SETTLE;
                            timer_d = DEAD_LOAD;
                        end
                    end else begin
                        presc_d = presc_q + PS_W'(1);
                    end
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    if (fault_clr && door_closed && !motor_cmd) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = FAULT;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        w_drive_on = (state_d == RAMP_UP) || (state_d == RUN) || (state_d == RAMP_DN);
        brake_d    = !(w_drive_on || (state_d == RELEASE));
        drv_up_d   = w_drive_on && (dir_lat_d == DIR_UP);
        drv_dn_d   = w_drive_on && (dir_lat_d == DIR_DN);
        busy_d     = (state_d != IDLE);
        fault_d    = (state_d == FAULT);
    end

    pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm_gen (
        .clk   (clk),
        .reset (reset),
        .en    (drv_up_d || drv_dn_d),
        .duty  (duty_d),
        .pwm   (pwm)
    );

    assign drv_up = drv_up_q;
    assign drv_dn = drv_dn_q;
    assign brake  = brake_q;
    assign duty   = duty_q;
    assign busy   = busy_q;
    assign fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_drive_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_drive_sequencer
//  Description : Self-checking bench for motor_drive_sequencer: directed
//                scenarios followed by random command traffic, all compared
//                every cycle against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_drive_sequencer;

    localparam int PWM_W    = 8;
    localparam int DUTY_MAX = 200;
    localparam int STEP     = 4;
    localparam int BRAKE_T  = 16;
    localparam int DEAD_T   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             motor_cmd = 1'b0;
    logic             dir_cmd = 1'b0;
    logic             door_closed = 1'b1;
    logic             estop = 1'b0;
    logic             fault_clr = 1'b0;
    logic             drv_up, drv_dn, pwm, brake, busy, fault;
    logic [PWM_W-1:0] duty;

    int checks = 0;
    int errors = 0;

    motor_drive_sequencer #(
        .PWM_W         (PWM_W),
        .DUTY_MAX      (DUTY_MAX),
        .RAMP_STEP_CYC (STEP),
        .BRAKE_CYC     (BRAKE_T),
        .DEAD_CYC      (DEAD_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .motor_cmd   (motor_cmd),
        .dir_cmd     (dir_cmd),
        .door_closed (door_closed),
        .estop       (estop),
        .fault_clr   (fault_clr),
        .drv_up      (drv_up),
        .drv_dn      (drv_dn),
        .pwm         (pwm),
        .brake       (brake),
        .duty        (duty),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int REST = 0, LIFT = 1, ACCEL = 2, CRUISE = 3, DECEL = 4, COAST = 5, TRIP = 6;
    int m_mode, m_wait, m_ticks, m_duty, m_cnt;
    bit m_dir;

    task automatic m_reset();
        m_mode = REST; m_wait = 0; m_ticks = 0; m_duty = 0; m_cnt = 0; m_dir = 1'b0;
    endtask

    // One clock edge worth of behaviour, using the inputs as they are now.
    task automatic m_update();
        bit go_on;
        m_cnt = (m_cnt + 1) % (1 << PWM_W);
        go_on = motor_cmd && (dir_cmd == m_dir);
        if (estop || (!door_closed && (m_mode inside {LIFT, ACCEL, CRUISE, DECEL}))) begin
            m_mode = TRIP;
            m_duty = 0;
            return;
        end
        case (m_mode)
            REST: if (motor_cmd && door_closed) begin
                m_mode = LIFT; m_dir = dir_cmd; m_wait = BRAKE_T;
            end
            LIFT: if (!motor_cmd) begin
                m_mode = COAST; m_wait = DEAD_T;
            end else begin
                m_wait--;
                if (m_wait == 0) begin m_mode = ACCEL; m_ticks = 0; end
            end
            ACCEL: if (!go_on) begin
                m_mode = DECEL; m_ticks = 0;
            end else if (m_duty == DUTY_MAX) begin
                m_mode = CRUISE;
            end else begin
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0; m_duty++;
                    if (m_duty == DUTY_MAX) m_mode = CRUISE;
                end
            end
            CRUISE: if (!go_on) begin m_mode = DECEL; m_ticks = 0; end
            DECEL: if (go_on) begin
                m_mode = ACCEL; m_ticks = 0;
            end else if (m_duty == 0) begin
                m_mode = COAST; m_wait = DEAD_T;
            end else begin
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0; m_duty--;
                    if (m_duty == 0) begin m_mode = COAST; m_wait = DEAD_T; end
                end
            end
            COAST: begin
                m_wait--;
                if (m_wait == 0) m_mode = REST;
            end
            TRIP: begin
                m_duty = 0;
                if (fault_clr && door_closed && !motor_cmd) m_mode = REST;
            end
            default: m_mode = TRIP;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        bit e_drive, e_up, e_dn;
        e_drive = m_mode inside {ACCEL, CRUISE, DECEL};
        e_up    = e_drive && m_dir;
        e_dn    = e_drive && !m_dir;
        chk("drv_up",  drv_up, e_up);
        chk("drv_dn",  drv_dn, e_dn);
        chk("brake",   brake,  !(e_drive || m_mode == LIFT));
        chk("duty",    duty,   m_duty);
        chk("pwm",     pwm,    e_drive && (m_cnt < m_duty));
        chk("busy",    busy,   m_mode != REST);
        chk("fault",   fault,  m_mode == TRIP);
        chk("overlap", drv_up & drv_dn, 1'b0);
        chk("drv_vs_brake", (drv_up | drv_dn) & brake, 1'b0);
    endtask

    task automatic step();
        m_update();
        @(posedge clk);
        #1;
        chk_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_brake", brake, 1'b1);
        chk("rst_drive", drv_up | drv_dn, 1'b0);
        chk("rst_pwm",   pwm, 1'b0);
        chk("rst_duty",  duty, 0);
        chk("rst_busy",  busy, 1'b0);
        chk("rst_fault", fault, 1'b0);
        reset = 1'b0;

        // Start upward from rest.
        motor_cmd = 1'b1; dir_cmd = 1'b1;
        step();
        chk("brake_released", brake, 1'b0);
        run(BRAKE_T - 1);
        chk("drive_before_brake_time", drv_up, 1'b0);
        step();
        chk("drive_up_on", drv_up, 1'b1);
        run(DUTY_MAX * STEP);
        chk("ramp_top", duty, DUTY_MAX);

        // Normal stop.
        motor_cmd = 1'b0;
        run(DUTY_MAX * STEP + 1);
        chk("stop_duty", duty, 0);
        chk("stop_brake", brake, 1'b1);
        run(DEAD_T - 1);
        chk("settle_busy", busy, 1'b1);
        step();
        chk("idle_busy", busy, 1'b0);

        // Reversal from RUN up to down through IDLE.
        motor_cmd = 1'b1; dir_cmd = 1'b1;
        run(1 + BRAKE_T + DUTY_MAX * STEP);
        dir_cmd = 1'b0;
        run(1 + DUTY_MAX * STEP + DEAD_T + 1 + BRAKE_T - 1);
        chk("rev_dn_early", drv_dn, 1'b0);
        step();
        chk("rev_dn_on", drv_dn, 1'b1);
        chk("rev_up_off", drv_up, 1'b0);
        run(DUTY_MAX * STEP);

        // Resume during ramp-down.
        motor_cmd = 1'b0;
        run(1 + 50 * STEP);
        chk("resume_low", duty, 150);
        motor_cmd = 1'b1;
        run(1 + 50 * STEP);
        chk("resume_top", duty, DUTY_MAX);
        chk("resume_brake", brake, 1'b0);

        // E-stop and fault clearing.
        estop = 1'b1;
        step();
        chk("estop_duty", duty, 0);
        chk("estop_fault", fault, 1'b1);
        chk("estop_brake", brake, 1'b1);
        estop = 1'b0; fault_clr = 1'b1;
        step();
        chk("clr_ignored", fault, 1'b1);
        motor_cmd = 1'b0;
        step();
        chk("clr_ok", fault, 1'b0);
        fault_clr = 1'b0;
        step();

        // Door opens during ramp-up.
        motor_cmd = 1'b1; dir_cmd = 1'b1;
        run(1 + BRAKE_T + 40);
        door_closed = 1'b0;
        step();
        chk("door_fault", fault, 1'b1);
        door_closed = 1'b1; motor_cmd = 1'b0; fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("door_clr", fault, 1'b0);

        // Asynchronous reset in RUN.
        motor_cmd = 1'b1;
        run(1 + BRAKE_T + DUTY_MAX * STEP);
        #2 reset = 1'b1;
        #1;
        chk("async_brake", brake, 1'b1);
        chk("async_pwm",   pwm, 1'b0);
        chk("async_duty",  duty, 0);
        chk("async_drive", drv_up | drv_dn, 1'b0);
        chk("async_busy",  busy, 1'b0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Random command traffic.
        for (int i = 0; i < 6000; i++) begin
            int r;
            if (estop) estop = ($urandom_range(0, 3) != 0);
            if (!door_closed) door_closed = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 999));
            if (r < 6)       motor_cmd = !motor_cmd;
            else if (r < 9)  dir_cmd = !dir_cmd;
            else if (r < 10) estop = 1'b1;
            else if (r < 11) door_closed = 1'b0;
            fault_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
